// File: rtl/mem_fifo_ctrl.sv
// rtl/mem_fifo_ctrl.sv - ready/valid FIFO controller over a single-port memory array
//
// Purpose:
//   Uses an external single-port array (combinational read) as FIFO storage
//   and adds one output holding register, giving DEPTH+1 entries in total.
//   The one array address port is shared, one operation per cycle:
//   READ (prefetch into the output register) > BYPASS > WRITE.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     push handshake, in_data push data
//   out_valid/out_ready   pop handshake, out_data head-of-FIFO data
//   count                 total occupancy 0..DEPTH+1 (registered)
//   mem_wr, mem_addr      array write enable and shared address
//   mem_wdata, mem_rdata  array write data / combinational read data
//   stats_clr, max_count  peak-occupancy watermark, only with
//                         MEM_FIFO_CTRL_STATS_EN defined
module mem_fifo_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = $clog2(DEPTH + 2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata
`ifdef MEM_FIFO_CTRL_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [CNT_WIDTH-1:0]  max_count
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(DEPTH);

  typedef enum logic [1:0] {
    OP_HOLD   = 2'd0,
    OP_READ   = 2'd1,
    OP_BYPASS = 2'd2,
    OP_WRITE  = 2'd3
  } op_e;

  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_nxt;
  logic [CNT_WIDTH-1:0]  mem_cnt, mem_cnt_nxt;
  logic                  out_valid_nxt;
  logic [WIDTH-1:0]      out_data_nxt;
  logic [CNT_WIDTH-1:0]  count_nxt;
  logic                  pop;
  logic                  slot_free;
  op_e                   op;

  // Explicit compare so non-power-of-2 depths wrap correctly.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  // Port arbitration. The output register being free at the next edge
  // (empty, or being popped now) is what lets a prefetch or a bypass land.
  always_comb begin
    pop       = out_valid && out_ready;
    slot_free = !out_valid || pop;
    op        = OP_HOLD;
    if (slot_free && (mem_cnt != '0)) begin
      op = OP_READ;
    end else if (slot_free) begin
      op = OP_BYPASS;
    end else if (mem_cnt < DEPTH_CNT) begin
      op = OP_WRITE;
    end
  end

  always_comb begin
    in_ready  = (op == OP_BYPASS) || (op == OP_WRITE);
    mem_wr    = (op == OP_WRITE) && in_valid;
    mem_addr  = (op == OP_WRITE) ? wr_ptr : rd_ptr;
    mem_wdata = in_data;
  end

  always_comb begin
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    mem_cnt_nxt   = mem_cnt;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    case (op)
      OP_READ: begin
        out_data_nxt  = mem_rdata;
        out_valid_nxt = 1'b1;
        rd_ptr_nxt    = ptr_inc(rd_ptr);
        mem_cnt_nxt   = mem_cnt - CNT_WIDTH'(1);
      end
      OP_BYPASS: begin
        if (in_valid) begin
          out_data_nxt  = in_data;
          out_valid_nxt = 1'b1;
        end else if (pop) begin
          // Nothing to refill with: drop valid, keep the last data.
          out_valid_nxt = 1'b0;
        end
      end
      OP_WRITE: begin
        // Output register is held here, so no pop can coincide.
        if (in_valid) begin
          wr_ptr_nxt  = ptr_inc(wr_ptr);
          mem_cnt_nxt = mem_cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
      end
    endcase
    count_nxt = mem_cnt_nxt + CNT_WIDTH'(out_valid_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      count     <= '0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      mem_cnt   <= mem_cnt_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      count     <= count_nxt;
    end
  end

`ifdef MEM_FIFO_CTRL_STATS_EN
  // Clear re-arms the watermark at the present occupancy and beats the update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_count <= '0;
    end else if (stats_clr) begin
      max_count <= count;
    end else if (count > max_count) begin
      max_count <= count;
    end
  end
`endif

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// tb/tb_mem_fifo_ctrl.sv - scoreboard bench for mem_fifo_ctrl
module tb_mem_fifo_ctrl;

  localparam int DA   = 16;
  localparam int DB   = 12;
  localparam int AWA  = $clog2(DA);
  localparam int CWA  = $clog2(DA + 2);
  localparam int AWB  = $clog2(DB);
  localparam int CWB  = $clog2(DB + 2);

  logic clk;
  logic rst_n;

  logic           a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_mem_wr;
  logic [7:0]     a_in_data, a_out_data, a_mem_wdata, a_mem_rdata;
  logic [CWA-1:0] a_count;
  logic [AWA-1:0] a_mem_addr;

  logic           b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_mem_wr;
  logic [7:0]     b_in_data, b_out_data, b_mem_wdata, b_mem_rdata;
  logic [CWB-1:0] b_count;
  logic [AWB-1:0] b_mem_addr;

`ifdef MEM_FIFO_CTRL_STATS_EN
  logic           a_stats_clr, b_stats_clr;
  logic [CWA-1:0] a_max_count;
  logic [CWB-1:0] b_max_count;
`endif

  mem_fifo_ctrl #(.WIDTH(8), .DEPTH(DA)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count),
    .mem_wr(a_mem_wr), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
`ifdef MEM_FIFO_CTRL_STATS_EN
    , .stats_clr(a_stats_clr), .max_count(a_max_count)
`endif
  );

  mem_fifo_ctrl #(.WIDTH(8), .DEPTH(DB)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count),
    .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
`ifdef MEM_FIFO_CTRL_STATS_EN
    , .stats_clr(b_stats_clr), .max_count(b_max_count)
`endif
  );

  // Array models: synchronous write, combinational read.
  logic [7:0] mem_a [DA];
  logic [7:0] mem_b [DB];

  always @(posedge clk) begin
    if (a_mem_wr) mem_a[a_mem_addr] <= a_mem_wdata;
    if (b_mem_wr && (int'(b_mem_addr) < DB)) mem_b[b_mem_addr] <= b_mem_wdata;
  end
  assign a_mem_rdata = mem_a[a_mem_addr];
  assign b_mem_rdata = (int'(b_mem_addr) < DB) ? mem_b[b_mem_addr] : 8'hEE;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counters and scoreboards; only the monitor writes the counters.
  int n_cmp  = 0;
  int n_fail = 0;
  int a_wr_total = 0;
  int b_a11_writes = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  // Directed checks posted by the stimulus, compared by the monitor.
  string post_name[$];
  int    post_act[$];
  int    post_exp[$];

  task automatic post(input string name, input int act, input int exp);
    post_name.push_back(name);
    post_act.push_back(act);
    post_exp.push_back(exp);
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  string m_name;
  int    m_act, m_exp;
  logic [7:0] m_head;

  always @(negedge clk) begin
    while (post_name.size() > 0) begin
      m_name = post_name.pop_front();
      m_act  = post_act.pop_front();
      m_exp  = post_exp.pop_front();
      cmp(m_name, m_act, m_exp);
    end
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) cmp("a_pop_unexpected", int'(a_out_data), -1);
        else begin
          m_head = qa.pop_front();
          cmp("a_out_data", int'(a_out_data), int'(m_head));
        end
      end
      if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) cmp("b_pop_unexpected", int'(b_out_data), -1);
        else begin
          m_head = qb.pop_front();
          cmp("b_out_data", int'(b_out_data), int'(m_head));
        end
      end
      if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
      if (a_mem_wr) begin
        a_wr_total++;
        cmp("a_mem_wr_needs_in_valid", int'(a_in_valid), 1);
      end
      if (b_mem_wr) begin
        cmp("b_mem_wr_needs_in_valid", int'(b_in_valid), 1);
        if (b_mem_addr == AWB'(DB - 1)) b_a11_writes++;
      end
      cmp("b_addr_range", int'(int'(b_mem_addr) < DB), 1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_empty(input string name, input int bound);
    for (int i = 0; i < bound && a_count != '0; i++) @(negedge clk);
    post(name, int'(a_count), 0);
  endtask

  int nextv, pushes, acc;

  initial begin
    rst_n = 1'b0;
    a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
`ifdef MEM_FIFO_CTRL_STATS_EN
    a_stats_clr = 0; b_stats_clr = 0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    post("rst_out_valid", int'(a_out_valid), 0);
    post("rst_count", int'(a_count), 0);
    post("rst_out_data", int'(a_out_data), 0);
    post("rst_in_ready", int'(a_in_ready), 1);
    post("rst_b_count", int'(b_count), 0);

    // Full fill: 17 of 0..20 accepted, then drain in order.
    for (int v = 0; v <= 20; v++) begin
      tick();
      a_in_valid = 1; a_in_data = 8'(v);
      @(negedge clk);
      post("fill_in_ready", int'(a_in_ready), (v < 17) ? 1 : 0);
      post("fill_count", int'(a_count), (v < 17) ? v : 17);
    end
    tick();
    a_in_valid = 0;
    @(negedge clk);
    post("full_count", int'(a_count), 17);
    post("full_out_data", int'(a_out_data), 0);
    post("full_in_ready", int'(a_in_ready), 0);
    tick();
    a_out_ready = 1;
    wait_a_empty("drain_count", 60);
    post("drain_sb_left", qa.size(), 0);

    // Bypass: one-cycle latency, no array write.
    acc = a_wr_total;
    tick();
    a_in_valid = 1; a_in_data = 8'hA5;
    @(negedge clk);
    post("byp_in_ready", int'(a_in_ready), 1);
    tick();
    a_in_valid = 0;
    @(negedge clk);
    post("byp_out_valid", int'(a_out_valid), 1);
    post("byp_out_data", int'(a_out_data), 8'hA5);
    tick();
    @(negedge clk);
    post("byp_empty_valid", int'(a_out_valid), 0);
    post("byp_hold_data", int'(a_out_data), 8'hA5);
    post("byp_mem_writes", a_wr_total - acc, 0);

    // Contention: 1 in output register + 4 in array, then push/pop every cycle.
    a_out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      a_in_valid = 1; a_in_data = 8'(10 + i);
    end
    tick();
    a_in_valid = 0;
    @(negedge clk);
    post("cont_count", int'(a_count), 5);
    nextv = 20;
    tick();
    a_in_valid = 1; a_in_data = 8'(nextv); a_out_ready = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      post("cont_in_ready", int'(a_in_ready), (c >= 4) ? 1 : 0);
      acc = int'(a_in_ready);
      tick();
      if (acc != 0) begin
        nextv++;
        a_in_data = 8'(nextv);
      end
    end
    a_in_valid = 0;
    wait_a_empty("cont_drain_count", 20);
    post("cont_accepted", nextv - 20, 4);

    // Wrap on DEPTH=12: 40 pushes with random valid/ready.
    pushes = 0;
    nextv = 8'h40;
    for (int cyc = 0; cyc < 3000 && (pushes < 40 || qb.size() > 0); cyc++) begin
      tick();
      b_in_valid  = (pushes < 40) && ($urandom_range(0, 1) == 1);
      b_in_data   = 8'(nextv);
      b_out_ready = (pushes < 40) ? ($urandom_range(0, 3) == 0) : 1'b1;
      @(negedge clk);
      if (b_in_valid && b_in_ready) begin
        pushes++;
        nextv++;
      end
    end
    tick();
    b_in_valid = 0; b_out_ready = 0;
    @(negedge clk);
    post("wrap_pushes", pushes, 40);
    post("wrap_sb_left", qb.size(), 0);
    post("wrap_count", int'(b_count), 0);
    post("wrap_reached_last_addr", int'(b_a11_writes > 0), 1);

    // Reset mid-operation with 9 entries held.
    a_out_ready = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      a_in_valid = 1; a_in_data = 8'(8'h30 + i);
    end
    tick();
    a_in_valid = 0;
    @(negedge clk);
    post("rmid_count_before", int'(a_count), 9);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    post("rmid_out_valid", int'(a_out_valid), 0);
    post("rmid_count", int'(a_count), 0);
    tick();
    rst_n = 1'b1;
    tick();
    a_in_valid = 1; a_in_data = 8'h5C;
    tick();
    a_in_data = 8'h5D;
    tick();
    a_in_valid = 0;
    @(negedge clk);
    post("rmid_new_data", int'(a_out_data), 8'h5C);
    post("rmid_new_count", int'(a_count), 2);
    tick();
    a_out_ready = 1;
    wait_a_empty("rmid_drain_count", 20);

`ifdef MEM_FIFO_CTRL_STATS_EN
    // Watermark: fill to 7, drain to 2, clear, push one.
    tick();
    a_out_ready = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      a_in_valid = 1; a_in_data = 8'(8'h70 + i);
    end
    tick();
    a_in_valid = 0;
    @(negedge clk);
    post("st_fill_count", int'(a_count), 7);
    tick();
    a_out_ready = 1;
    repeat (5) @(posedge clk);
    #1 a_out_ready = 0;
    @(negedge clk);
    post("st_drain_count", int'(a_count), 2);
    @(negedge clk);
    post("st_max_peak", int'(a_max_count), 7);
    tick();
    a_stats_clr = 1;
    tick();
    a_stats_clr = 0;
    @(negedge clk);
    post("st_max_clr", int'(a_max_count), 2);
    a_in_valid = 1; a_in_data = 8'h77;
    tick();
    a_in_valid = 0;
    tick();
    @(negedge clk);
    post("st_max_push", int'(a_max_count), 3);
    tick();
    a_out_ready = 1;
    wait_a_empty("st_drain_count0", 20);
`endif

    tick();
    a_out_ready = 0;
    for (int i = 0; i < 10 && post_name.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
